// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty/almost-empty and occupancy logic for an async FIFO.
// Every output is a flop, except raddr, which is sliced from the registered binary pointer.
module rptr_empty_lvl #(
  parameter int ADDRSIZE  = 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow,
  output logic                rerr
);

  localparam logic [ADDRSIZE:0] DEPTH_V = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] AE_V    = AEMPTY_TH[ADDRSIZE:0];

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rptr_d;
  logic [ADDRSIZE:0] rlevel_q, rlevel_d;
  logic              rempty_q, rempty_d;
  logic              raempty_q, raempty_d;
  logic              runderflow_q, runderflow_d;
  logic              rerr_q, rerr_d;

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rgraynext;
  logic              rd_ok;

  // Gray-to-binary conversion of the synchronised write pointer.
  always_comb begin
    wbin = '0;
    wbin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--)
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
  end

  always_comb begin
    rd_ok        = rinc & ~rempty_q;
    rbin_d       = rbin_q + {{ADDRSIZE{1'b0}}, rd_ok};
    rgraynext    = rbin_d ^ (rbin_d >> 1);
    rptr_d       = rgraynext;
    rlevel_d     = wbin - rbin_d;
    rempty_d     = (rgraynext == rq2_wptr);
    raempty_d    = (rlevel_d <= AE_V);
    // A level above DEPTH can only come from corrupted pointers; the flag is sticky.
    runderflow_d = runderflow_q | (rinc & rempty_q);
    rerr_d       = rerr_q | (rlevel_d > DEPTH_V);
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
      rerr_q       <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
      rerr_q       <= rerr_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;
  assign rerr       = rerr_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl with ADDRSIZE=4, AEMPTY_TH=2.
module tb_rptr_empty_lvl;

  logic       rclk = 1'b0;
  logic       rrst, rinc;
  logic [4:0] rq2_wptr;
  logic [3:0] raddr;
  logic [4:0] rptr, rlevel;
  logic       rempty, raempty, runderflow, rerr;

  int checks = 0;
  int errors = 0;

  rptr_empty_lvl #(.ADDRSIZE(4), .AEMPTY_TH(2)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
    .rlevel(rlevel), .runderflow(runderflow), .rerr(rerr)
  );

  always #5 rclk = ~rclk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic test_reset();
    rrst = 1'b1; rinc = 1'b0; rq2_wptr = 5'b00000;
    tick(); tick();
    checks++; if (raddr !== 4'd0)      begin errors++; $display("FAIL reset_raddr got %0d exp 0", raddr); end
    checks++; if (rptr !== 5'b00000)   begin errors++; $display("FAIL reset_rptr got %b exp 00000", rptr); end
    checks++; if (rempty !== 1'b1)     begin errors++; $display("FAIL reset_rempty got %b exp 1", rempty); end
    checks++; if (raempty !== 1'b1)    begin errors++; $display("FAIL reset_raempty got %b exp 1", raempty); end
    checks++; if (rlevel !== 5'd0)     begin errors++; $display("FAIL reset_rlevel got %0d exp 0", rlevel); end
    checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL reset_runderflow got %b exp 0", runderflow); end
    checks++; if (rerr !== 1'b0)       begin errors++; $display("FAIL reset_rerr got %b exp 0", rerr); end
    rrst = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [4:0] exp_ptr [1:5];
    logic [4:0] exp_lvl [1:5];
    logic       exp_ae  [1:5];
    logic       exp_em  [1:5];
    exp_ptr = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111};
    exp_lvl = '{5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    exp_ae  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_em  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rq2_wptr = 5'b00111; rinc = 1'b0;
    tick();
    checks++; if (rlevel !== 5'd5)  begin errors++; $display("FAIL fill_rlevel got %0d exp 5", rlevel); end
    checks++; if (rempty !== 1'b0)  begin errors++; $display("FAIL fill_rempty got %b exp 0", rempty); end
    checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL fill_raempty got %b exp 0", raempty); end
    checks++; if (raddr !== 4'd0)   begin errors++; $display("FAIL fill_raddr got %0d exp 0", raddr); end
    rinc = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++; if (raddr !== 4'(k))       begin errors++; $display("FAIL drain_raddr[%0d] got %0d exp %0d", k, raddr, k); end
      checks++; if (rptr !== exp_ptr[k])   begin errors++; $display("FAIL drain_rptr[%0d] got %b exp %b", k, rptr, exp_ptr[k]); end
      checks++; if (rlevel !== exp_lvl[k]) begin errors++; $display("FAIL drain_rlevel[%0d] got %0d exp %0d", k, rlevel, exp_lvl[k]); end
      checks++; if (raempty !== exp_ae[k]) begin errors++; $display("FAIL drain_raempty[%0d] got %b exp %b", k, raempty, exp_ae[k]); end
      checks++; if (rempty !== exp_em[k])  begin errors++; $display("FAIL drain_rempty[%0d] got %b exp %b", k, rempty, exp_em[k]); end
    end
    rinc = 1'b0;
  endtask

  task automatic test_underflow();
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    checks++; if (raddr !== 4'd5)       begin errors++; $display("FAIL uflow_raddr got %0d exp 5", raddr); end
    checks++; if (rptr !== 5'b00111)    begin errors++; $display("FAIL uflow_rptr got %b exp 00111", rptr); end
    checks++; if (runderflow !== 1'b1)  begin errors++; $display("FAIL uflow_flag got %b exp 1", runderflow); end
    rq2_wptr = 5'b00100; // bin 7
    tick();
    checks++; if (rlevel !== 5'd2)      begin errors++; $display("FAIL uflow_refill_rlevel got %0d exp 2", rlevel); end
    rinc = 1'b1;
    tick(); tick();
    rinc = 1'b0;
    checks++; if (raddr !== 4'd7)       begin errors++; $display("FAIL uflow_reads_raddr got %0d exp 7", raddr); end
    checks++; if (rempty !== 1'b1)      begin errors++; $display("FAIL uflow_reads_rempty got %b exp 1", rempty); end
    checks++; if (runderflow !== 1'b1)  begin errors++; $display("FAIL uflow_sticky got %b exp 1", runderflow); end
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    checks++; if (runderflow !== 1'b0)  begin errors++; $display("FAIL uflow_cleared got %b exp 0", runderflow); end
  endtask

  // Each cycle the writer advances by one while a read is accepted: level stays at 1.
  task automatic test_back_to_back_wrap();
    logic [4:0] nb;
    rq2_wptr = 5'b00001; rinc = 1'b0;
    tick();
    checks++; if (rlevel !== 5'd1) begin errors++; $display("FAIL wrap_prefill_rlevel got %0d exp 1", rlevel); end
    rinc = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      nb = 5'(i + 1);
      rq2_wptr = nb ^ (nb >> 1);
      tick();
      checks++; if (rlevel !== 5'd1)  begin errors++; $display("FAIL wrap_rlevel[%0d] got %0d exp 1", i, rlevel); end
      checks++; if (rempty !== 1'b0)  begin errors++; $display("FAIL wrap_rempty[%0d] got %b exp 0", i, rempty); end
      if (i == 15) begin
        checks++; if (raddr !== 4'd15) begin errors++; $display("FAIL wrap_raddr15 got %0d exp 15", raddr); end
      end
      if (i == 16) begin
        checks++; if (raddr !== 4'd0)     begin errors++; $display("FAIL wrap_raddr16 got %0d exp 0", raddr); end
        checks++; if (rptr !== 5'b11000)  begin errors++; $display("FAIL wrap_rptr16 got %b exp 11000", rptr); end
      end
      if (i == 20) begin
        checks++; if (raddr !== 4'd4)     begin errors++; $display("FAIL wrap_raddr20 got %0d exp 4", raddr); end
        checks++; if (rptr !== 5'b11110)  begin errors++; $display("FAIL wrap_rptr20 got %b exp 11110", rptr); end
      end
    end
    tick();
    rinc = 1'b0;
    checks++; if (rempty !== 1'b1)     begin errors++; $display("FAIL wrap_final_rempty got %b exp 1", rempty); end
    checks++; if (rlevel !== 5'd0)     begin errors++; $display("FAIL wrap_final_rlevel got %0d exp 0", rlevel); end
    checks++; if (rptr !== 5'b11111)   begin errors++; $display("FAIL wrap_final_rptr got %b exp 11111", rptr); end
    checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL wrap_no_uflow got %b exp 0", runderflow); end
  endtask

  task automatic test_full_err();
    rrst = 1'b1; rinc = 1'b0; rq2_wptr = 5'b00000;
    tick();
    rrst = 1'b0; rq2_wptr = 5'b11000; // bin 16
    tick();
    checks++; if (rlevel !== 5'd16) begin errors++; $display("FAIL full_rlevel got %0d exp 16", rlevel); end
    checks++; if (rempty !== 1'b0)  begin errors++; $display("FAIL full_rempty got %b exp 0", rempty); end
    checks++; if (raempty !== 1'b0) begin errors++; $display("FAIL full_raempty got %b exp 0", raempty); end
    checks++; if (rerr !== 1'b0)    begin errors++; $display("FAIL full_rerr got %b exp 0", rerr); end
    rq2_wptr = 5'b11001; // bin 17
    tick();
    checks++; if (rerr !== 1'b1)    begin errors++; $display("FAIL err_set got %b exp 1", rerr); end
    checks++; if (rlevel !== 5'd17) begin errors++; $display("FAIL err_rlevel got %0d exp 17", rlevel); end
    rq2_wptr = 5'b11000;
    tick();
    checks++; if (rerr !== 1'b1)    begin errors++; $display("FAIL err_sticky got %b exp 1", rerr); end
  endtask

  task automatic test_reset_mid_read();
    rrst = 1'b1;
    tick();
    rrst = 1'b0; rq2_wptr = 5'b00010; // bin 3
    tick();
    checks++; if (rlevel !== 5'd3)     begin errors++; $display("FAIL mid_pre_rlevel got %0d exp 3", rlevel); end
    rinc = 1'b1; rrst = 1'b1;
    tick();
    checks++; if (raddr !== 4'd0)      begin errors++; $display("FAIL mid_raddr got %0d exp 0", raddr); end
    checks++; if (rptr !== 5'b00000)   begin errors++; $display("FAIL mid_rptr got %b exp 00000", rptr); end
    checks++; if (rlevel !== 5'd0)     begin errors++; $display("FAIL mid_rlevel got %0d exp 0", rlevel); end
    checks++; if (rempty !== 1'b1)     begin errors++; $display("FAIL mid_rempty got %b exp 1", rempty); end
    checks++; if (raempty !== 1'b1)    begin errors++; $display("FAIL mid_raempty got %b exp 1", raempty); end
    checks++; if (rerr !== 1'b0)       begin errors++; $display("FAIL mid_rerr got %b exp 0", rerr); end
    checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL mid_runderflow got %b exp 0", runderflow); end
    rrst = 1'b0; rinc = 1'b0;
    tick();
    checks++; if (rlevel !== 5'd3)     begin errors++; $display("FAIL post_reset_rlevel got %0d exp 3", rlevel); end
    checks++; if (rempty !== 1'b0)     begin errors++; $display("FAIL post_reset_rempty got %b exp 0", rempty); end
  endtask

  initial begin
    rrst = 1'b1; rinc = 1'b0; rq2_wptr = 5'b00000;
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back_wrap();
    test_full_err();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
